// File: rtl/vga_fb_writer_if.sv
// Pixel write request channel into the frame buffer writer.
// The requester drives the pixel and valid. The writer answers with ready.
interface vga_fb_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [2:0]  wr_rgb;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_rgb, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_rgb, output wr_ready);
endinterface

// File: rtl/vga_fb_writer.sv
// Write-side controller for the packed 800x480 RGB111 frame buffer.
// It performs single-pixel read-modify-writes and full-screen fills, and yields the read port to the display.
module vga_fb_writer #(
  parameter int H_PIXELS     = 800,
  parameter int V_PIXELS     = 480,
  parameter int PIX_PER_WORD = 5,
  parameter int WORDS        = H_PIXELS * V_PIXELS / PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  vga_fb_writer_if.slave    wr,
  input  logic              clr_start,
  input  logic [2:0]        clr_rgb,
  output logic              busy,
  output logic              dropped,
  input  logic              disp_req,
  input  logic [16:0]       disp_addr,
  output logic [16:0]       ram_read_address,
  input  logic [15:0]       ram_q,
  output logic [16:0]       ram_write_address,
  output logic [15:0]       ram_d,
  output logic              ram_we
);

  typedef enum logic [2:0] {IDLE, CALC, RD, MOD, FILL} state_t;

  state_t      state;
  logic [10:0] x_q;
  logic [10:0] y_q;
  logic [2:0]  rgb_q;
  logic [2:0]  slot_q;
  logic [16:0] rd_addr;
  logic [16:0] wr_addr;
  logic        we_q;
  logic        drop_q;
  logic [15:0] fill_word;

  logic [18:0] idx_c;
  logic [16:0] word_c;
  logic [2:0]  slot_c;
  logic [15:0] merged;

  assign idx_c  = 19'(y_q) * 19'(H_PIXELS) + 19'(x_q);
  assign word_c = 17'(idx_c / 19'(PIX_PER_WORD));
  assign slot_c = 3'(idx_c % 19'(PIX_PER_WORD));

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    merged = ram_q;
    for (int s = 0; s < PIX_PER_WORD; s++) begin
      if (slot_q == 3'(s)) merged[3*s +: 3] = rgb_q;
    end
    merged[15] = 1'b0;
  end

  // Reset gates the enable combinationally so an in-flight write dies in the reset cycle itself.
  assign ram_we            = we_q && !reset;
  assign ram_write_address = wr_addr;
  assign ram_d             = (state == MOD) ? merged : fill_word;
  assign ram_read_address  = disp_req ? disp_addr : rd_addr;
  assign busy              = (state != IDLE);
  assign dropped           = drop_q;
  assign wr.wr_ready       = (state == IDLE) && !clr_start && !reset;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      slot_q    <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      we_q      <= 1'b0;
      drop_q    <= 1'b0;
      fill_word <= '0;
    end else begin
      we_q   <= 1'b0;
      drop_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            fill_word <= {1'b0, {5{clr_rgb}}};
            wr_addr   <= '0;
            we_q      <= 1'b1;
            state     <= FILL;
          end else if (wr.wr_valid) begin
            x_q   <= wr.wr_x;
            y_q   <= wr.wr_y;
            rgb_q <= wr.wr_rgb;
            state <= CALC;
          end
        end
        CALC: begin
          slot_q <= slot_c;
          if (x_q >= 11'(H_PIXELS) || y_q >= 11'(V_PIXELS)) begin
            drop_q <= 1'b1;
            state  <= IDLE;
          end else begin
            rd_addr <= word_c;
            state   <= RD;
          end
        end
        RD: begin
          // The read only counts as issued in a cycle the display leaves the port free.
          if (!disp_req) begin
            wr_addr <= rd_addr;
            we_q    <= 1'b1;
            state   <= MOD;
          end
        end
        MOD: state <= IDLE;
        FILL: begin
          // wr_addr doubles as the fill counter.
          if (wr_addr == 17'(WORDS - 1)) begin
            state <= IDLE;
          end else begin
            wr_addr <= wr_addr + 17'd1;
            we_q    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Randomized bench for vga_fb_writer with a RAM model and a pixel-level reference image.
// Every RAM write is logged and compared to the image predicted from the packing rules.
module tb_vga_fb_writer;
  localparam int WORDS = 76800;

  typedef struct {
    int          at;
    logic [16:0] addr;
    logic [15:0] data;
  } wr_ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr_start = 1'b0;
  logic [2:0]  clr_rgb = 3'd0;
  logic        busy;
  logic        dropped;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [16:0] ram_read_address;
  logic [16:0] ram_write_address;
  logic [15:0] ram_q;
  logic [15:0] ram_d;
  logic        ram_we;

  vga_fb_writer_if wr_if ();

  vga_fb_writer dut (
    .clk               (clk),
    .reset             (reset),
    .wr                (wr_if),
    .clr_start         (clr_start),
    .clr_rgb           (clr_rgb),
    .busy              (busy),
    .dropped           (dropped),
    .disp_req          (disp_req),
    .disp_addr         (disp_addr),
    .ram_read_address  (ram_read_address),
    .ram_q             (ram_q),
    .ram_write_address (ram_write_address),
    .ram_d             (ram_d),
    .ram_we            (ram_we)
  );

  always #5 clk = ~clk;

  logic [15:0] mem     [WORDS];
  logic [15:0] ref_mem [WORDS];
  int          cyc = 0;
  int          drop_cnt = 0;
  wr_ev_t      wlog[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // RAM with a registered read port, plus write and drop monitors.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ram_q <= mem[ram_read_address];
    if (ram_we) begin
      mem[ram_write_address] <= ram_d;
      wlog.push_back('{cyc, ram_write_address, ram_d});
    end
    if (dropped) drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pix_write(input int x, input int y, input logic [2:0] rgb, input int hold,
                           input bit poke_clr);
    int n0, d0, acc, t, idx, w, s, exp_at;
    bit in_range;
    n0 = wlog.size();
    d0 = drop_cnt;
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_x     = 11'(x);
    wr_if.wr_y     = 11'(y);
    wr_if.wr_rgb   = rgb;
    #1;
    t = 0;
    while (!wr_if.wr_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    check("ready_wait", wr_if.wr_ready, 1);
    acc = cyc;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      disp_req  = 1'b1;
      disp_addr = 17'($urandom_range(0, WORDS - 1));
      clr_start = poke_clr && (i == 0);
      clr_rgb   = 3'($urandom);
      #1;
      check("disp_mux", ram_read_address, disp_addr);
      @(negedge clk);
    end
    disp_req  = 1'b0;
    clr_start = 1'b0;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk); t++;
    end
    check("idle_wait", busy, 0);
    #1;
    check("ready_after", wr_if.wr_ready, 1);
    @(negedge clk);

    in_range = (x < 800) && (y < 480);
    if (in_range) begin
      idx = y * 800 + x;
      w   = idx / 5;
      s   = idx % 5;
      ref_mem[w] = ((ref_mem[w] & ~(16'd7 << (3 * s))) & 16'h7FFF) | (16'(rgb) << (3 * s));
      exp_at = acc + 3 + ((hold > 1) ? hold - 1 : 0);
    end
    check("n_writes", wlog.size() - n0, in_range ? 1 : 0);
    check("n_drops", drop_cnt - d0, in_range ? 0 : 1);
    if (in_range && wlog.size() == n0 + 1) begin
      check("wr_addr", wlog[n0].addr, w);
      check("wr_data", wlog[n0].data, ref_mem[w]);
      check("wr_latency", wlog[n0].at, exp_at);
    end
  endtask

  task automatic fill_run(input logic [2:0] rgb, input int abort_at);
    int n0, acc, t, cnt, bad;
    logic [15:0] fw;
    n0 = wlog.size();
    fw = 16'd0;
    for (int s = 0; s < 5; s++) fw = fw | (16'(rgb) << (3 * s));
    @(negedge clk);
    clr_start      = 1'b1;
    clr_rgb        = rgb;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_x     = 11'($urandom_range(0, 799));
    wr_if.wr_y     = 11'($urandom_range(0, 479));
    #1;
    check("clr_beats_wr", wr_if.wr_ready, 0);
    acc = cyc;
    @(negedge clk);
    clr_start      = 1'b0;
    wr_if.wr_valid = 1'b0;
    clr_rgb        = ~rgb;
    check("fill_busy", busy, 1);
    t = 0;
    if (abort_at < 0) begin
      while (busy && t < 80000) begin
        @(negedge clk); t++;
      end
      check("fill_done", busy, 0);
      @(negedge clk);
      cnt = WORDS;
    end else begin
      while (!(ram_write_address == 17'(abort_at) && ram_we) && t < 5000) begin
        @(negedge clk); t++;
      end
      reset = 1'b1;
      #1;
      check("rst_we_off", ram_we, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_ready", wr_if.wr_ready, 1);
      cnt = abort_at;
    end
    check("fill_count", wlog.size() - n0, cnt);
    bad = 0;
    for (int i = 0; i < cnt && n0 + i < wlog.size(); i++) begin
      if (wlog[n0 + i].addr != 17'(i) || wlog[n0 + i].data != fw || wlog[n0 + i].at != acc + 1 + i)
        bad++;
      ref_mem[i] = fw;
    end
    check("fill_seq", bad, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int bad;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_x     = '0;
    wr_if.wr_y     = '0;
    wr_if.wr_rgb   = '0;
    for (int i = 0; i < WORDS; i++) begin
      v = 16'($urandom);
      mem[i]    <= v;
      ref_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_low", wr_if.wr_ready, 0);
    check("rst_busy0", busy, 0);
    check("rst_we0", ram_we, 0);
    check("rst_waddr0", ram_write_address, 0);
    check("rst_d0", ram_d, 0);
    check("rst_drop0", dropped, 0);
    check("rst_raddr0", ram_read_address, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_rst", wr_if.wr_ready, 1);

    mem[1] <= 16'h7FFF;
    ref_mem[1] = 16'h7FFF;
    pix_write(7, 0, 3'b010, 0, 0);
    if (wlog.size() > 0) check("single_lit", wlog[$].data, 16'h7EBF);

    mem[160] <= 16'h0000;
    ref_mem[160] = 16'h0000;
    pix_write(4, 1, 3'b111, 0, 0);
    if (wlog.size() > 0) begin
      check("row_addr_lit", wlog[$].addr, 160);
      check("row_data_lit", wlog[$].data, 16'h7000);
    end

    pix_write($urandom_range(0, 799), $urandom_range(0, 479), 3'($urandom), 10, 1);

    pix_write(800, 0, 3'b001, 0, 0);
    pix_write(0, 480, 3'b100, 0, 0);

    for (int x = 10; x < 15; x++) pix_write(x, 0, 3'($urandom), 0, 0);

    for (int i = 0; i < 24; i++)
      pix_write($urandom_range(0, 819), $urandom_range(0, 489), 3'($urandom),
                $urandom_range(0, 3), 0);

    fill_run(3'b101, -1);
    if (wlog.size() > 0) check("fill_lit", wlog[$].data, 16'h5B6D);

    for (int i = 0; i < 4; i++)
      pix_write($urandom_range(0, 799), $urandom_range(0, 479), 3'($urandom),
                $urandom_range(0, 2), 0);

    fill_run(3'($urandom), 1000);
    pix_write(3, 2, 3'($urandom), 0, 0);
    pix_write(799, 479, 3'($urandom), 1, 0);

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_fb_writer.md
Name: vga_fb_writer

Overview:
- Write-side controller for the 800x480, 3-bit-RGB frame buffer RAM. Each 16-bit word packs 5 pixels; bit 15 is unused.
- Accepts single-pixel write requests and performs a read-modify-write on the packed word.
- Also runs a full-screen clear/fill.
- Shares the RAM's single read port with the display fetch path. The display always has priority on that port.

Parameters:
- H_PIXELS, 800, visible pixels per line.
- V_PIXELS, 480, visible lines.
- PIX_PER_WORD, 5, pixels packed per RAM word (fixed layout; not intended to change).
- WORDS, 76800, RAM depth = H_PIXELS*V_PIXELS/PIX_PER_WORD.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  request accepted when wr_valid && wr_ready.
- wr_x  in  11  pixel column.
- wr_y  in  11  pixel row.
- wr_rgb  in  3  {R,G,B}.
- clr_start  in  1  one-cycle pulse: fill whole frame with clr_rgb.
- clr_rgb  in  3  fill colour.
- busy  out  1  high whenever not IDLE.
- dropped  out  1  one-cycle pulse: accepted request was out of range.
- disp_req  in  1  display needs the read port this cycle.
- disp_addr  in  17  display read address.
- ram_read_address  out  17  to RAM read port.
- ram_q  in  16  RAM read data; registered, valid the cycle after the address is presented.
- ram_write_address  out  17  to RAM write port.
- ram_d  out  16  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- Packing:
  - idx = y*800 + x (19 bits).
  - word = idx/5 (17 bits).
  - slot = idx%5.
  - Slot s occupies bits [3s+2:3s] with R at 3s+2, G at 3s+1, B at 3s.
  - Bit 15 is always written 0.
- Read-port mux (combinational): ram_read_address = disp_req ? disp_addr : rd_addr_reg. The writer may only consider its read issued in a cycle where disp_req=0.
- FSM states: IDLE, CALC, RD, MOD, FILL.
- IDLE:
  - wr_ready=1.
  - If clr_start=1, go to FILL and load fill counter to 0. clr_start beats wr_valid: wr_ready is forced 0 that cycle, so no write is accepted.
  - Else if wr_valid=1, latch x/y/rgb and go to CALC.
- CALC:
  - Register word and slot.
  - If x>=800 or y>=480: pulse dropped, go to IDLE, no RAM access.
  - Otherwise go to RD.
- RD:
  - Drive rd_addr_reg=word.
  - If disp_req=0 this cycle, the read is issued; go to MOD.
  - Else stay in RD (stall indefinitely, no timeout).
- MOD:
  - ram_q holds the old word.
  - Drive ram_we=1, ram_write_address=word, ram_d = old word with slot bits replaced by rgb and bit15=0.
  - Return to IDLE.
  - Best-case latency: accept edge to write edge = 3 cycles (CALC, RD, MOD).
- FILL:
  - One word per cycle: ram_we=1, ram_write_address=cnt, ram_d={1'b0, clr_rgb x5}.
  - No reads.
  - cnt increments; after writing word 76799, go to IDLE.
  - 76800 write cycles total.
  - clr_rgb is latched at clr_start.
- Write requests during busy are not accepted (wr_ready=0). clr_start while not IDLE is ignored.
- Display reading a word mid-RMW sees the pre-write value; this is acceptable (one-frame glitch only).
- Reset values:
  - State IDLE.
  - wr_ready=0 during the reset cycle, 1 the cycle after reset deasserts.
  - busy=0, dropped=0, ram_we=0, ram_write_address=0, ram_d=0, rd_addr_reg=0, fill counter=0.
- Reset mid-operation (RD/MOD/FILL): abort at once, ram_we=0 from the reset cycle on. A partial fill leaves the RAM partially written; no rollback.
- Only one ram_we per accepted pixel write; never a write in IDLE/CALC/RD.

Test Plan:
- Single write: RAM word 1 = 16'h7FFF, write x=7,y=0,rgb=3'b010 with disp_req=0 -> after 3 cycles ram_we=1 for exactly one cycle, addr 1, ram_d=16'h7EBF; wr_ready back to 1 the next cycle.
- Row addressing: write x=4,y=1,rgb=3'b111 on zeroed RAM -> idx 804, addr 160, slot 4, ram_d=16'h7000.
- Read-port contention: hold disp_req=1 for 10 cycles during a write -> ram_read_address==disp_addr throughout; FSM stays in RD; write occurs 2 cycles after disp_req falls.
- Out of range: write x=800,y=0 and x=0,y=480 -> dropped pulses once each; ram_we never asserts.
- Fill then priority:
  - clr_start and wr_valid in the same IDLE cycle with clr_rgb=3'b101 -> no write accepted, busy=1.
  - 76800 consecutive writes, addresses 0..76799, each ram_d=16'h5B6D; then IDLE.
- Reset mid-fill: assert reset at fill word 1000 -> ram_we=0 that cycle; next cycle busy=0, wr_ready=1; a following pixel write works normally.
